// File: rtl/segre_mmu_arb.sv
// segre_mmu_arb: multiplexes NUM_CH cache lane fill/writeback channels onto one main-memory port,
// one transaction at a time, with round-robin or fixed-priority arbitration.
module segre_mmu_arb #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_SIZE = 32,
  parameter int LANE_SIZE = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic                          clk_i,
  input  logic                          rsn_i,
  input  logic [NUM_CH-1:0]             ch_req_i,
  input  logic [NUM_CH-1:0]             ch_we_i,
  input  logic [NUM_CH*ADDR_SIZE-1:0]   ch_addr_i,
  input  logic [NUM_CH*LANE_SIZE-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]             ch_rdy_o,
  output logic [LANE_SIZE-1:0]          ch_data_o,
  output logic                          busy_o,
  output logic                          mm_rd_req_o,
  output logic                          mm_wr_req_o,
  output logic [ADDR_SIZE-1:0]          mm_addr_o,
  output logic [LANE_SIZE-1:0]          mm_data_o,
  input  logic                          mm_data_rdy_i,
  input  logic [LANE_SIZE-1:0]          mm_data_i
);
  localparam int IW = $clog2(NUM_CH);
  localparam logic [1:0] IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, win;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LANE_SIZE-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_CH-1:0] rdy_q, rdy_d;

  // Search order starts at ptr (round-robin) or 0 (fixed); descending walk lets the first hit win.
  function automatic logic [IW-1:0] pick(input logic [NUM_CH-1:0] req, input logic [IW-1:0] ptr);
    int j;
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = (PRIO_MODE != 0) ? i : (int'(ptr) + i) % NUM_CH;
      if (req[j]) pick = IW'(j);
    end
  endfunction

  assign win = pick(ch_req_i, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rdy_d   = '0;
    case (state_q)
      IDLE: if (|ch_req_i) begin
        state_d = MEM;
        gnt_d   = win;
        ptr_d   = (win == IW'(NUM_CH - 1)) ? '0 : win + IW'(1);
        rd_d    = !ch_we_i[win];
        wr_d    = ch_we_i[win];
        addr_d  = ch_addr_i[win*ADDR_SIZE +: ADDR_SIZE];
        wdata_d = ch_data_i[win*LANE_SIZE +: LANE_SIZE];
      end
      MEM: if (mm_data_rdy_i) begin
        state_d = RESP;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        rdy_d   = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_q;
        rdata_d = rd_q ? mm_data_i : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ch_rdy_o    = rdy_q;
  assign ch_data_o   = rdata_q;
  assign busy_o      = state_q != IDLE;
  assign mm_rd_req_o = rd_q;
  assign mm_wr_req_o = wr_q;
  assign mm_addr_o   = addr_q;
  assign mm_data_o   = wdata_q;
endmodule

// File: tb/tb_segre_mmu_arb.sv
// tb_segre_mmu_arb: directed checks of three arbiter configurations (2ch RR, 4ch fixed, 4ch RR).
module tb_segre_mmu_arb;
  logic clk_i = 1'b0, rsn_i = 1'b0;
  logic mm_rdy = 1'b0;
  logic [127:0] mm_rdata = '0;
  int tests = 0, fails = 0;
  always #5 clk_i = ~clk_i;

  logic [1:0] a_req = '0, a_we = '0, a_rdy;
  logic [63:0] a_addr = '0;
  logic [255:0] a_wdata = '0;
  logic [127:0] a_cdata, a_mdata;
  logic a_busy, a_rd, a_wr;
  logic [31:0] a_maddr;
  segre_mmu_arb #(.NUM_CH(2), .PRIO_MODE(0)) u_a (
    .clk_i(clk_i), .rsn_i(rsn_i), .ch_req_i(a_req), .ch_we_i(a_we), .ch_addr_i(a_addr),
    .ch_data_i(a_wdata), .ch_rdy_o(a_rdy), .ch_data_o(a_cdata), .busy_o(a_busy),
    .mm_rd_req_o(a_rd), .mm_wr_req_o(a_wr), .mm_addr_o(a_maddr), .mm_data_o(a_mdata),
    .mm_data_rdy_i(mm_rdy), .mm_data_i(mm_rdata));

  logic [3:0] b_req = '0, b_rdy;
  logic [127:0] b_addr = '0;
  logic [511:0] b_wdata = '0;
  logic [127:0] b_cdata, b_mdata;
  logic b_busy, b_rd, b_wr;
  logic [31:0] b_maddr;
  segre_mmu_arb #(.NUM_CH(4), .PRIO_MODE(1)) u_b (
    .clk_i(clk_i), .rsn_i(rsn_i), .ch_req_i(b_req), .ch_we_i(4'b0), .ch_addr_i(b_addr),
    .ch_data_i(b_wdata), .ch_rdy_o(b_rdy), .ch_data_o(b_cdata), .busy_o(b_busy),
    .mm_rd_req_o(b_rd), .mm_wr_req_o(b_wr), .mm_addr_o(b_maddr), .mm_data_o(b_mdata),
    .mm_data_rdy_i(mm_rdy), .mm_data_i(mm_rdata));

  logic [3:0] c_req = '0, c_rdy;
  logic [127:0] c_addr = '0;
  logic [511:0] c_wdata = '0;
  logic [127:0] c_cdata, c_mdata;
  logic c_busy, c_rd, c_wr;
  logic [31:0] c_maddr;
  segre_mmu_arb #(.NUM_CH(4), .PRIO_MODE(0)) u_c (
    .clk_i(clk_i), .rsn_i(rsn_i), .ch_req_i(c_req), .ch_we_i(4'b0), .ch_addr_i(c_addr),
    .ch_data_i(c_wdata), .ch_rdy_o(c_rdy), .ch_data_o(c_cdata), .busy_o(c_busy),
    .mm_rd_req_o(c_rd), .mm_wr_req_o(c_wr), .mm_addr_o(c_maddr), .mm_data_o(c_mdata),
    .mm_data_rdy_i(mm_rdy), .mm_data_i(mm_rdata));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk_i);
  endtask

  // Entered on the negedge of the MEM cycle; leaves on the negedge of the following IDLE cycle.
  task automatic a_txn(input int ch, input logic [31:0] addr, input logic [127:0] d, input string tag);
    chk({tag, "_addr"}, 128'(a_maddr), 128'(addr));
    chk({tag, "_rd"}, 128'(a_rd), 128'(1));
    chk({tag, "_wr"}, 128'(a_wr), 128'(0));
    chk({tag, "_busy"}, 128'(a_busy), 128'(1));
    mm_rdy = 1'b1; mm_rdata = d;
    step;
    chk({tag, "_rdy"}, 128'(a_rdy), 128'(2'b01 << ch));
    chk({tag, "_data"}, a_cdata, d);
    chk({tag, "_rd_off"}, 128'(a_rd), 128'(0));
    a_req[ch] = 1'b0; mm_rdy = 1'b0;
    step;
    chk({tag, "_idle"}, 128'({a_busy, a_rdy}), 128'(0));
  endtask

  initial begin
    logic [3:0] c_vec [3];
    int c_exp [3];
    c_vec = '{4'b1000, 4'b1001, 4'b1001};
    c_exp = '{3, 0, 3};
    step; step;
    chk("rst_rdy", 128'(a_rdy), 128'(0));
    rsn_i = 1'b1;
    step;
    chk("rst_outs", 128'({a_busy, a_rd, a_wr}), 128'(0));
    chk("rst_addr", 128'(a_maddr), 128'(0));
    chk("rst_cdata", a_cdata, 128'(0));
    chk("rst_mdata", a_mdata, 128'(0));

    a_addr[31:0] = 32'h100; a_req = 2'b01;
    step;
    a_txn(0, 32'h100, {16{8'hA5}}, "fill");

    a_we = 2'b10; a_addr[63:32] = 32'h2040; a_wdata[255:128] = {4{32'hDEADBEEF}}; a_req = 2'b10;
    step;
    chk("wb_wr", 128'({a_wr, a_rd}), 128'(2'b10));
    chk("wb_addr", 128'(a_maddr), 128'(32'h2040));
    chk("wb_mdata", a_mdata, {4{32'hDEADBEEF}});
    a_wdata[255:128] = '1; a_addr[63:32] = 32'h0;
    step;
    chk("wb_hold", 128'({a_wr, a_rd}), 128'(2'b10));
    chk("wb_frozen", a_mdata, {4{32'hDEADBEEF}});
    chk("wb_faddr", 128'(a_maddr), 128'(32'h2040));
    mm_rdy = 1'b1; mm_rdata = {4{32'h11111111}};
    step;
    chk("wb_rdy", 128'(a_rdy), 128'(2'b10));
    chk("wb_cdata", a_cdata, {16{8'hA5}});
    a_req = 2'b00; a_we = 2'b00; mm_rdy = 1'b0;
    step;

    a_addr = {32'h2000, 32'h1000};
    for (int r = 0; r < 2; r++) begin
      a_req = 2'b11;
      step;
      a_txn(0, 32'h1000, {8{16'h1234 + 16'(r)}}, $sformatf("rr%0d_c0", r));
      step;
      a_txn(1, 32'h2000, {8{16'h5678 + 16'(r)}}, $sformatf("rr%0d_c1", r));
    end

    mm_rdy = 1'b1; mm_rdata = '1;
    step;
    chk("idle_ign", 128'({a_busy, a_rdy}), 128'(0));
    chk("idle_data", a_cdata, {8{16'h5679}});
    mm_rdy = 1'b0;

    for (int i = 0; i < 4; i++) b_addr[i*32 +: 32] = 32'h4000 + 32'(i);
    b_req = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      step;
      chk($sformatf("fp%0d_addr", n), 128'(b_maddr), 128'(32'h4001));
      mm_rdy = 1'b1; mm_rdata = 128'(n);
      step;
      chk($sformatf("fp%0d_rdy", n), 128'(b_rdy), 128'(4'b0010));
      if (n == 2) b_req = '0;
      mm_rdy = 1'b0;
      step;
    end
    chk("fp_idle", 128'(b_busy), 128'(0));

    for (int i = 0; i < 4; i++) c_addr[i*32 +: 32] = 32'h3000 + 32'(i * 16);
    for (int n = 0; n < 3; n++) begin
      c_req = c_vec[n];
      step;
      chk($sformatf("rr4_%0d_addr", n), 128'(c_maddr), 128'(32'h3000 + 32'(c_exp[n] * 16)));
      mm_rdy = 1'b1;
      step;
      chk($sformatf("rr4_%0d_rdy", n), 128'(c_rdy), 128'(4'b0001 << c_exp[n]));
      c_req = '0; mm_rdy = 1'b0;
      step;
    end

    a_addr[31:0] = 32'h100; a_req = 2'b01;
    step;
    chk("mid_rd", 128'(a_rd), 128'(1));
    step; step;
    rsn_i = 1'b0; a_req = '0;
    #1;
    chk("mid_abort", 128'({a_rd, a_wr, a_busy}), 128'(0));
    chk("mid_cdata", a_cdata, 128'(0));
    step;
    rsn_i = 1'b1; mm_rdy = 1'b1; mm_rdata = '1;
    step;
    chk("mid_norpy", 128'(a_rdy), 128'(0));
    mm_rdy = 1'b0;
    a_addr[63:32] = 32'h2080; a_req = 2'b10;
    step;
    a_txn(1, 32'h2080, {4{32'hCAFEF00D}}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
